// File: rtl/guard_patrol.sv
// Guard patrol motion source: walks the guard clockwise around a rectangular loop,
// one step per synchronized frame tick, dwelling PAUSE_FRAMES ticks at each corner.
module guard_patrol #(
  parameter int X_MIN        = 100,
  parameter int X_MAX        = 400,
  parameter int Y_MIN        = 80,
  parameter int Y_MAX        = 300,
  parameter int STEP         = 1,
  parameter int PAUSE_FRAMES = 30
) (
  input  logic       vga_clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       enable,
  output logic [9:0] GuardX,
  output logic [9:0] GuardY,
  output logic [2:0] direction_guard
);

  // Encoding order matters: each move state is its pause state + 1, and UP + 1 wraps to PAUSE_TL.
  typedef enum logic [2:0] {
    PAUSE_TL = 3'd0,
    RIGHT    = 3'd1,
    PAUSE_TR = 3'd2,
    DOWN     = 3'd3,
    PAUSE_BR = 3'd4,
    LEFT     = 3'd5,
    PAUSE_BL = 3'd6,
    UP       = 3'd7
  } state_t;

  localparam logic [2:0] DIR_LEFT  = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_UP    = 3'b011;
  localparam logic [2:0] DIR_STOP  = 3'b111;

  localparam int CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_FRAMES - 1);

  localparam logic [9:0]  X_MIN10 = 10'(X_MIN);
  localparam logic [9:0]  X_MAX10 = 10'(X_MAX);
  localparam logic [9:0]  Y_MIN10 = 10'(Y_MIN);
  localparam logic [9:0]  Y_MAX10 = 10'(Y_MAX);
  localparam logic [10:0] STEP11  = 11'(STEP);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [2:0]       dir_q, dir_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             tick;

  logic [10:0] x_inc, y_inc, x_dec, y_dec;
  logic        x_hit_max, y_hit_max, x_hit_min, y_hit_min;

  assign tick = sync2_q & ~prev_q;

  // Saturation tests are done before subtracting so the decrement can never wrap.
  assign x_inc     = {1'b0, x_q} + STEP11;
  assign y_inc     = {1'b0, y_q} + STEP11;
  assign x_dec     = {1'b0, x_q} - STEP11;
  assign y_dec     = {1'b0, y_q} - STEP11;
  assign x_hit_max = x_inc >= {1'b0, X_MAX10};
  assign y_hit_max = y_inc >= {1'b0, Y_MAX10};
  assign x_hit_min = {1'b0, x_q} <= ({1'b0, X_MIN10} + STEP11);
  assign y_hit_min = {1'b0, y_q} <= ({1'b0, Y_MIN10} + STEP11);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    if (tick && enable) begin
      unique case (state_q)
        PAUSE_TL, PAUSE_TR, PAUSE_BR, PAUSE_BL: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = state_t'(state_q + 3'd1);
            unique case (state_q)
              PAUSE_TL: dir_d = DIR_RIGHT;
              PAUSE_TR: dir_d = DIR_DOWN;
              PAUSE_BR: dir_d = DIR_LEFT;
              default:  dir_d = DIR_UP;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RIGHT: begin
          if (x_hit_max) begin
            x_d     = X_MAX10;
            state_d = PAUSE_TR;
            dir_d   = DIR_STOP;
          end else begin
            x_d = x_inc[9:0];
          end
        end
        DOWN: begin
          if (y_hit_max) begin
            y_d     = Y_MAX10;
            state_d = PAUSE_BR;
            dir_d   = DIR_STOP;
          end else begin
            y_d = y_inc[9:0];
          end
        end
        LEFT: begin
          if (x_hit_min) begin
            x_d     = X_MIN10;
            state_d = PAUSE_BL;
            dir_d   = DIR_STOP;
          end else begin
            x_d = x_dec[9:0];
          end
        end
        default: begin
          if (y_hit_min) begin
            y_d     = Y_MIN10;
            state_d = PAUSE_TL;
            dir_d   = DIR_STOP;
          end else begin
            y_d = y_dec[9:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= PAUSE_TL;
      cnt_q   <= '0;
      x_q     <= X_MIN10;
      y_q     <= Y_MIN10;
      dir_q   <= DIR_STOP;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
    end
  end

  assign GuardX          = x_q;
  assign GuardY          = y_q;
  assign direction_guard = enable ? dir_q : DIR_STOP;

endmodule
